// File: rtl/lut_bank_ctrl_pkg.sv
// Shared types and sizing helpers for the double-banked LUT controller.
package lut_ctrl_pkg;

   typedef enum logic [1:0] {
      INIT    = 2'd0,
      IDLE    = 2'd1,
      PENDING = 2'd2
   } state_t;

   localparam int PX_WIDTH_DEFAULT = 10;
   localparam int LUT_DEPTH        = 2 ** PX_WIDTH_DEFAULT;

   // One extra bit so the fill counter walks both banks back to back.
   function automatic int fill_cnt_width(input int px_width);
      return px_width + 1;
   endfunction

   function automatic int lut_depth(input int px_width);
      return 2 ** px_width;
   endfunction

endpackage

// File: rtl/lut_bank_ctrl_if.sv
// Host-side LUT write and commit handshake between the CSR block and the bank controller.
interface lut_bank_ctrl_if #(
   parameter int PX_WIDTH = 10
);

   logic                wr_valid;
   logic                wr_ready;
   logic [PX_WIDTH-1:0] wr_addr;
   logic [PX_WIDTH-1:0] wr_data;
   logic                commit;

   modport master (
      output wr_valid,
      output wr_addr,
      output wr_data,
      output commit,
      input  wr_ready
   );

   modport slave (
      input  wr_valid,
      input  wr_addr,
      input  wr_data,
      input  commit,
      output wr_ready
   );

endinterface

// File: rtl/lut_bank_ctrl_swap_timer.sv
// Counts cycles spent waiting for a start-of-frame; flags expiry so the controller can force a swap.
module lut_swap_timer #(
   parameter int SWAP_TIMEOUT = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int TW = (SWAP_TIMEOUT > 1) ? $clog2(SWAP_TIMEOUT) : 1;
   localparam logic [TW-1:0] LAST = (SWAP_TIMEOUT > 0) ? TW'(SWAP_TIMEOUT - 1) : '0;

   logic [TW-1:0] count_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clear) begin
         count_q <= '0;
      end else if (enable && !expire) begin
         count_q <= count_q + 1'b1;
      end
   end

   // A zero timeout means the swap is never forced.
   assign expire = (SWAP_TIMEOUT > 0) && enable && (count_q == LAST);

endmodule

// File: rtl/lut_bank_ctrl.sv
// Double-banked LUT controller: identity fill after reset, host writes to the shadow bank, SOF-aligned swap.
module lut_bank_ctrl
   import lut_ctrl_pkg::*;
#(
   parameter int PX_WIDTH     = 10,
   parameter int SWAP_TIMEOUT = 0
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   lut_bank_ctrl_if.slave      host,
   input  logic                sof_valid_i,
   input  logic                sof_ready_i,
   input  logic                sof_user_i,
   output logic                mem_wr_en_o,
   output logic                mem_wr_bank_o,
   output logic [PX_WIDTH-1:0] mem_wr_addr_o,
   output logic [PX_WIDTH-1:0] mem_wr_data_o,
   output logic                active_bank_o,
   output logic                busy_o,
   output logic                swap_done_o,
   output logic                swap_forced_o
);

   localparam int CW = fill_cnt_width(PX_WIDTH);

   state_t              state_q, state_d;
   logic [CW-1:0]       fill_cnt_q;
   logic                pending_q;
   logic                active_q;
   logic                swap_done_q, swap_forced_q;
   logic                mem_en_q, mem_bank_q;
   logic [PX_WIDTH-1:0] mem_addr_q, mem_data_q;

   logic sof, expire, do_swap, forced, fill_last, wr_accept;

   assign sof       = sof_valid_i & sof_ready_i & sof_user_i;
   assign fill_last = &fill_cnt_q;
   assign wr_accept = host.wr_valid && (state_q == IDLE);

   assign host.wr_ready = (state_q == IDLE);
   assign busy_o        = (state_q != IDLE);
   assign active_bank_o = active_q;
   assign swap_done_o   = swap_done_q;
   assign swap_forced_o = swap_forced_q;
   assign mem_wr_en_o   = mem_en_q;
   assign mem_wr_bank_o = mem_bank_q;
   assign mem_wr_addr_o = mem_addr_q;
   assign mem_wr_data_o = mem_data_q;

   lut_swap_timer #(
      .SWAP_TIMEOUT (SWAP_TIMEOUT)
   ) u_swap_timer (
      .clk    (clk_i),
      .rst_n  (rst_n_i),
      .clear  (state_q != PENDING),
      .enable (state_q == PENDING),
      .expire (expire)
   );

   // A real SOF wins over a simultaneous timeout, so forced is only set without SOF.
   always_comb begin
      state_d = state_q;
      do_swap = 1'b0;
      forced  = 1'b0;
      case (state_q)
         INIT: begin
            if (fill_last) begin
               state_d = (pending_q || host.commit) ? PENDING : IDLE;
            end
         end
         IDLE: begin
            if (host.commit) begin
               state_d = PENDING;
            end
         end
         PENDING: begin
            if (sof || expire) begin
               state_d = IDLE;
               do_swap = 1'b1;
               forced  = !sof;
            end
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         state_q       <= INIT;
         fill_cnt_q    <= '0;
         pending_q     <= 1'b0;
         active_q      <= 1'b0;
         swap_done_q   <= 1'b0;
         swap_forced_q <= 1'b0;
         mem_en_q      <= 1'b0;
         mem_bank_q    <= 1'b0;
         mem_addr_q    <= '0;
         mem_data_q    <= '0;
      end else begin
         state_q       <= state_d;
         swap_done_q   <= do_swap;
         swap_forced_q <= forced;
         mem_en_q      <= 1'b0;
         if (do_swap) begin
            active_q <= ~active_q;
         end
         // Counter MSB picks the bank, the low bits are both address and identity data.
         if (state_q == INIT) begin
            fill_cnt_q <= fill_cnt_q + 1'b1;
            pending_q  <= (pending_q || host.commit) && !fill_last;
            mem_en_q   <= 1'b1;
            mem_bank_q <= fill_cnt_q[CW-1];
            mem_addr_q <= fill_cnt_q[PX_WIDTH-1:0];
            mem_data_q <= fill_cnt_q[PX_WIDTH-1:0];
         end else if (wr_accept) begin
            mem_en_q   <= 1'b1;
            mem_bank_q <= ~active_q;
            mem_addr_q <= host.wr_addr;
            mem_data_q <= host.wr_data;
         end
      end
   end

endmodule

// File: tb/tb_lut_bank_ctrl.sv
// Scoreboard bench for lut_bank_ctrl: one instance without timeout, one with SWAP_TIMEOUT=8, sharing stimulus.
module tb_lut_bank_ctrl;

   localparam int PXW = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic sof_valid = 1'b0, sof_ready = 1'b0, sof_user = 1'b0;

   always #5 clk = ~clk;

   lut_bank_ctrl_if #(.PX_WIDTH(PXW)) host0 ();
   lut_bank_ctrl_if #(.PX_WIDTH(PXW)) host8 ();

   logic           mem_en0, mem_bank0, active0, busy0, done0, forced0;
   logic [PXW-1:0] mem_addr0, mem_data0;
   logic           mem_en8, mem_bank8, active8, busy8, done8, forced8;
   logic [PXW-1:0] mem_addr8, mem_data8;

   lut_bank_ctrl #(.PX_WIDTH(PXW), .SWAP_TIMEOUT(0)) dut0 (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .host          (host0),
      .sof_valid_i   (sof_valid),
      .sof_ready_i   (sof_ready),
      .sof_user_i    (sof_user),
      .mem_wr_en_o   (mem_en0),
      .mem_wr_bank_o (mem_bank0),
      .mem_wr_addr_o (mem_addr0),
      .mem_wr_data_o (mem_data0),
      .active_bank_o (active0),
      .busy_o        (busy0),
      .swap_done_o   (done0),
      .swap_forced_o (forced0)
   );

   lut_bank_ctrl #(.PX_WIDTH(PXW), .SWAP_TIMEOUT(8)) dut8 (
      .clk_i         (clk),
      .rst_n_i       (rst_n),
      .host          (host8),
      .sof_valid_i   (sof_valid),
      .sof_ready_i   (sof_ready),
      .sof_user_i    (sof_user),
      .mem_wr_en_o   (mem_en8),
      .mem_wr_bank_o (mem_bank8),
      .mem_wr_addr_o (mem_addr8),
      .mem_wr_data_o (mem_data8),
      .active_bank_o (active8),
      .busy_o        (busy8),
      .swap_done_o   (done8),
      .swap_forced_o (forced8)
   );

   typedef struct {
      int             cyc;
      logic           bank;
      logic [PXW-1:0] addr;
      logic [PXW-1:0] data;
   } wr_exp_t;

   typedef struct {
      int   cyc;
      logic bank;
      logic forced;
   } sw_exp_t;

   wr_exp_t wr_q[$];
   sw_exp_t sw0_q[$];
   sw_exp_t sw8_q[$];
   wr_exp_t we;
   sw_exp_t se;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic drive(input logic v, input logic [PXW-1:0] a, input logic [PXW-1:0] d,
                        input logic c, input logic sv, input logic sr, input logic su);
      host0.wr_valid = v;  host0.wr_addr = a;  host0.wr_data = d;  host0.commit = c;
      host8.wr_valid = v;  host8.wr_addr = a;  host8.wr_data = d;  host8.commit = c;
      sof_valid = sv;
      sof_ready = sr;
      sof_user  = su;
   endtask

   task automatic applyStimulus(input logic v, input logic [PXW-1:0] a, input logic [PXW-1:0] d,
                                input logic c, input logic sv, input logic sr, input logic su);
      drive(v, a, d, c, sv, sr, su);
      @(negedge clk);
   endtask

   task automatic applyIdle();
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic waitCycle(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic pushWrite(input int c, input logic b, input logic [PXW-1:0] a, input logic [PXW-1:0] d);
      wr_exp_t e;
      e.cyc = c;  e.bank = b;  e.addr = a;  e.data = d;
      wr_q.push_back(e);
   endtask

   task automatic pushSwap(input bit to8, input int c, input logic b, input logic f);
      sw_exp_t e;
      e.cyc = c;  e.bank = b;  e.forced = f;
      if (to8) sw8_q.push_back(e);
      else     sw0_q.push_back(e);
   endtask

   // Identity fill: bank 0 entries 0..15, then bank 1 entries 0..15.
   task automatic pushInit(input int start);
      logic [4:0] idx;
      for (int i = 0; i < 2 * (2 ** PXW); i++) begin
         idx = 5'(i);
         pushWrite(start + i, idx[4], idx[3:0], idx[3:0]);
      end
   endtask

   always @(negedge clk) begin
      if (mem_en0 === 1'b1) begin
         if (wr_q.size() == 0) begin
            checkOutput("unexpected_mem_wr", 1, 0);
         end else begin
            we = wr_q.pop_front();
            checkOutput("mem_wr_cycle", cyc, we.cyc);
            checkOutput("mem_wr_bank", mem_bank0, we.bank);
            checkOutput("mem_wr_addr", mem_addr0, we.addr);
            checkOutput("mem_wr_data", mem_data0, we.data);
         end
      end
      if (done0 === 1'b1) begin
         if (sw0_q.size() == 0) begin
            checkOutput("unexpected_swap0", 1, 0);
         end else begin
            se = sw0_q.pop_front();
            checkOutput("swap0_cycle", cyc, se.cyc);
            checkOutput("swap0_bank", active0, se.bank);
            checkOutput("swap0_forced", forced0, se.forced);
         end
      end
      if (forced0 === 1'b1 && done0 !== 1'b1) checkOutput("forced0_without_done", 1, 0);
      if (done8 === 1'b1) begin
         if (sw8_q.size() == 0) begin
            checkOutput("unexpected_swap8", 1, 0);
         end else begin
            se = sw8_q.pop_front();
            checkOutput("swap8_cycle", cyc, se.cyc);
            checkOutput("swap8_bank", active8, se.bank);
            checkOutput("swap8_forced", forced8, se.forced);
         end
      end
      if (forced8 === 1'b1 && done8 !== 1'b1) checkOutput("forced8_without_done", 1, 0);
   end

   initial begin
      int r0, c, w, e, d;
      drive(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);

      // Reset values
      checkOutput("rst_mem_en", mem_en0, 0);
      checkOutput("rst_mem_addr", mem_addr0, 0);
      checkOutput("rst_mem_data", mem_data0, 0);
      checkOutput("rst_busy", busy0, 1);
      checkOutput("rst_ready", host0.wr_ready, 0);
      checkOutput("rst_active", active0, 0);
      checkOutput("rst_swap_done", done0, 0);

      r0 = cyc;
      rst_n = 1'b1;
      pushInit(r0 + 1);
      waitCycle(r0 + 31);
      checkOutput("init_busy_before_end", busy0, 1);
      checkOutput("init_ready_before_end", host0.wr_ready, 0);
      waitCycle(r0 + 32);
      checkOutput("init_busy_falls", busy0, 0);
      checkOutput("init_ready_rises", host0.wr_ready, 1);
      checkOutput("init_active", active0, 0);
      checkOutput("init_busy_falls_to8", busy8, 0);

      // Back-to-back shadow writes land in bank 1
      w = cyc;
      pushWrite(w + 1, 1'b1, 4'd3, 4'd9);
      applyStimulus(1'b1, 4'd3, 4'd9, 1'b0, 1'b0, 1'b0, 1'b0);
      pushWrite(w + 2, 1'b1, 4'd5, 4'd12);
      applyStimulus(1'b1, 4'd5, 4'd12, 1'b0, 1'b0, 1'b0, 1'b0);
      pushWrite(w + 3, 1'b1, 4'd15, 4'd0);
      applyStimulus(1'b1, 4'd15, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      applyIdle();

      // Commit with a same-cycle write; dut0 waits for SOF, dut8 forces after 8 cycles
      c = cyc;
      pushWrite(c + 1, 1'b1, 4'd7, 4'd2);
      pushSwap(1'b1, c + 9, 1'b1, 1'b1);
      applyStimulus(1'b1, 4'd7, 4'd2, 1'b1, 1'b0, 1'b0, 1'b0);
      applyIdle();
      checkOutput("pending_ready0", host0.wr_ready, 0);
      checkOutput("pending_busy0", busy0, 1);
      checkOutput("pending_ready8", host8.wr_ready, 0);
      waitCycle(c + 5);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1);
      applyIdle();
      waitCycle(c + 10);
      checkOutput("forced_active8", active8, 1);
      checkOutput("forced_busy8", busy8, 0);
      checkOutput("nosof_active0", active0, 0);
      checkOutput("nosof_ready0", host0.wr_ready, 0);
      waitCycle(c + 50);
      pushSwap(1'b0, c + 51, 1'b1, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyIdle();
      waitCycle(c + 52);
      checkOutput("sof_active0", active0, 1);
      checkOutput("sof_ready0", host0.wr_ready, 1);
      checkOutput("sof_done_one_cycle", done0, 0);
      checkOutput("idle_sof_ignored8", active8, 1);

      // Shadow is now bank 0
      w = cyc;
      pushWrite(w + 1, 1'b0, 4'd1, 4'd4);
      applyStimulus(1'b1, 4'd1, 4'd4, 1'b0, 1'b0, 1'b0, 1'b0);
      applyIdle();

      // Reset while pending, then commit during the refill
      e = cyc;
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyIdle();
      waitCycle(e + 3);
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("midrst_active0", active0, 0);
      checkOutput("midrst_active8", active8, 0);
      checkOutput("midrst_busy0", busy0, 1);
      checkOutput("midrst_mem_en", mem_en0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      pushInit(e + 6);
      pushSwap(1'b1, e + 45, 1'b1, 1'b1);
      pushSwap(1'b0, e + 61, 1'b1, 1'b0);
      waitCycle(e + 10);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyIdle();
      waitCycle(e + 38);
      checkOutput("init_commit_busy0", busy0, 1);
      checkOutput("init_commit_ready0", host0.wr_ready, 0);
      waitCycle(e + 60);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyIdle();
      waitCycle(e + 62);
      checkOutput("init_commit_active0", active0, 1);
      checkOutput("init_commit_active8", active8, 1);

      // SOF on the timeout expiry cycle counts as a normal swap
      d = cyc;
      pushSwap(1'b0, d + 9, 1'b0, 1'b0);
      pushSwap(1'b1, d + 9, 1'b0, 1'b0);
      applyStimulus(1'b0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      applyIdle();
      waitCycle(d + 8);
      applyStimulus(1'b0, '0, '0, 1'b0, 1'b1, 1'b1, 1'b1);
      applyIdle();
      waitCycle(d + 11);
      checkOutput("expiry_sof_active0", active0, 0);
      checkOutput("expiry_sof_active8", active8, 0);

      waitCycle(d + 15);
      checkOutput("wr_q_drained", wr_q.size(), 0);
      checkOutput("sw0_q_drained", sw0_q.size(), 0);
      checkOutput("sw8_q_drained", sw8_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/lut_bank_ctrl.md
Name: lut_bank_ctrl

Overview:
Controller for the double-banked LUT RAM used by the LUT pixel-mapping stage.
- Initialises both banks to an identity ramp after reset.
- Routes host writes into the shadow (inactive) bank.
- Swaps the active bank only on a video start-of-frame, so no frame is ever mapped through a half-loaded table.
- Sits between the LUT CSR block (host write/commit) and the LUT RAM plus pixel datapath (bank select).

Parameters:
PX_WIDTH, 10, pixel width; also LUT address and data width. LUT depth = 2**PX_WIDTH.
SWAP_TIMEOUT, 0, cycles to wait for SOF after commit before a forced swap; 0 = never force.

Ports:
clk_i  in  1  single clock
rst_n_i  in  1  reset, synchronous, active-low
host_wr_valid_i  in  1  host LUT write request
host_wr_ready_o  out  1  write accepted when valid&ready
host_wr_addr_i  in  PX_WIDTH  LUT entry index
host_wr_data_i  in  PX_WIDTH  LUT entry value
commit_i  in  1  single-cycle pulse: shadow bank complete, request swap
sof_valid_i  in  1  video tvalid at datapath input
sof_ready_i  in  1  video tready at datapath input
sof_user_i  in  1  video tuser (start of frame)
mem_wr_en_o  out  1  LUT RAM write strobe
mem_wr_bank_o  out  1  bank written
mem_wr_addr_o  out  PX_WIDTH  RAM address
mem_wr_data_o  out  PX_WIDTH  RAM data
active_bank_o  out  1  bank read by pixel datapath
busy_o  out  1  state != IDLE
swap_done_o  out  1  one-cycle pulse on every bank swap
swap_forced_o  out  1  one-cycle pulse when a swap was caused by timeout

Behaviour:
Reset (rst_n_i=0 sampled at clk_i edge):
- State goes to INIT; fill counter = 0; active_bank_o=0.
- mem_wr_en_o=0, addr/data/bank=0, host_wr_ready_o=0, busy_o=1, swap_done_o=0, swap_forced_o=0.
- Pending-commit flag and timeout counter cleared.
- Reset mid-operation abandons any load or pending swap and restarts INIT.

Fill counter width is PX_WIDTH+1. MSB selects bank, LSBs select address.

INIT:
- Each cycle: mem_wr_en_o=1, bank=cnt[MSB], addr=cnt[PX_WIDTH-1:0], data=addr (identity).
- 2*2**PX_WIDTH cycles, then go to IDLE.
- host_wr_ready_o=0 throughout.
- A commit_i in INIT sets the pending flag. On leaving INIT, go to PENDING instead of IDLE.

IDLE:
- host_wr_ready_o=1.
- An accepted write appears on the mem port the next cycle with bank = ~active_bank_o. Latency 1; one write per cycle sustained.
- On commit_i, go to PENDING. If a write is accepted in the same cycle, that write still lands in the shadow bank before any swap.

PENDING:
- host_wr_ready_o=0; further commit_i pulses are ignored.
- SOF = sof_valid_i & sof_ready_i & sof_user_i.
- On the SOF cycle: next cycle active_bank_o toggles, swap_done_o=1 for one cycle, state returns to IDLE.
- The SOF beat itself is still mapped by the old bank; the toggle is registered. The datapath compensates with its own pipeline alignment; this block does not.
- If SWAP_TIMEOUT>0: a counter starts at 0 on entry and increments each cycle. When it reaches SWAP_TIMEOUT-1 with no SOF, swap anyway and pulse swap_forced_o together with swap_done_o.
- SOF and timeout in the same cycle count as an SOF swap; swap_forced_o=0.
- An SOF seen while not in PENDING has no effect.

mem_wr_* outputs are registered. mem_wr_en_o is low whenever no write is issued; addr/data hold their last values.

Decomposition:
- Package lut_ctrl_pkg: state enum (INIT, IDLE, PENDING); constant LUT_DEPTH derived from PX_WIDTH; function giving the fill-counter width.
- One sub-module is natural: lut_swap_timer (timeout counter with enable/clear and expiry pulse). Everything else stays flat.

Test Plan:
- Reset, PX_WIDTH=4: exactly 32 mem writes; bank0 addr0..15 then bank1 addr0..15, data==addr; busy_o falls at cycle 32; host_wr_ready_o rises with it; active_bank_o=0.
- IDLE write addr=3 data=9: next cycle mem_wr_en_o=1, bank=1, addr=3, data=9; back-to-back writes sustain 1/cycle.
- Commit, then SOF 50 cycles later: host_wr_ready_o=0 during wait; next cycle after SOF active_bank_o=1 and swap_done_o pulses once; a non-SOF or tready=0 beat causes no swap.
- SWAP_TIMEOUT=8, commit with no SOF: swap 8 cycles after entering PENDING; swap_forced_o pulses with swap_done_o. SOF on the expiry cycle gives swap_forced_o=0.
- Commit during INIT: after fill completes, state=PENDING; the first SOF swaps to bank 1.
- rst_n_i low while PENDING: active_bank_o returns to 0, INIT refill restarts, and no swap_done_o pulse occurs.
